// File: rtl/rv32i_dmem_ctrl_if.sv
// Bus bundle between the RV32I memory stage, the load/store sequencer and
// the byte-wide data RAM. The sequencer uses the slave view; whoever plays
// core and RAM (a wrapper or a bench) uses the master view.
interface rv32i_dmem_ctrl_if #(
  parameter int AWIDTH = 12
);
  // core side
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              busy;
  logic              done;
  logic              err;
  // RAM side
  logic [AWIDTH-1:0] ram_address;
  logic [7:0]        ram_data;
  logic              ram_wren;
  logic [7:0]        ram_q;

  modport master (
    output req, we, funct3, addr, wdata, ram_q,
    input  rdata, busy, done, err, ram_address, ram_data, ram_wren
  );

  modport slave (
    input  req, we, funct3, addr, wdata, ram_q,
    output rdata, busy, done, err, ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/rv32i_dmem_ctrl.sv
// Load/store sequencer: splits one 32-bit access into 1, 2 or 4 byte cycles
// on a single-port byte RAM with registered read data, reassembles loads
// little-endian and applies RISC-V sign/zero extension.
module rv32i_dmem_ctrl #(
  parameter int AWIDTH = 12
) (
  input  logic            clock,
  input  logic            reset,
  rv32i_dmem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [AWIDTH-1:0] r_base;
  logic              r_we;
  logic              r_zext;      // funct3[2]: zero-extend loads
  logic [31:0]       r_wdata;
  logic [1:0]        r_nm1;       // byte count minus one (0, 1 or 3)
  logic [1:0]        r_k;         // byte index within the access
  logic              r_err;
  logic [3:0][7:0]   r_bytes;     // captured load bytes 0..2
  logic [31:0]       r_rdata;

  logic              w_illegal;
  logic              w_last;
  logic              w_issue;
  logic [3:0][7:0]   w_full;
  logic [31:0]       w_load_result;
  logic              w_unused;

  // Upper address bits fall outside the RAM and are deliberately dropped.
  assign w_unused = ^bus.addr[31:AWIDTH];

  // Reserved widths (x11, 11x) and unsigned stores have no meaning.
  assign w_illegal = (bus.funct3[1:0] == 2'b11) ||
                     (bus.funct3[2:1] == 2'b11) ||
                     (bus.we && bus.funct3[2]);

  assign w_last = (r_k == r_nm1);

  // The final load byte arrives on ram_q during DRAIN; splice it into its
  // lane so the result can be written to rdata in that same cycle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_full[gi] = (r_nm1 == 2'(gi)) ? bus.ram_q : r_bytes[gi];
  end

  // Sign- or zero-extend the assembled load from bit 8N-1.
  always_comb begin
    w_load_result = w_full;
    case (r_nm1)
      2'd0:    w_load_result = {{24{~r_zext & w_full[0][7]}}, w_full[0]};
      2'd1:    w_load_result = {{16{~r_zext & w_full[1][7]}}, w_full[1], w_full[0]};
      default: w_load_result = w_full;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          w_state_next = w_illegal ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_last) begin
          w_state_next = r_we ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register plus request latch, byte index and load capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_we    <= 1'b0;
      r_zext  <= 1'b0;
      r_wdata <= '0;
      r_nm1   <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
      r_bytes <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_base  <= bus.addr[AWIDTH-1:0];
            r_we    <= bus.we;
            r_zext  <= bus.funct3[2];
            r_wdata <= bus.wdata;
            r_nm1   <= (bus.funct3[1:0] == 2'b00) ? 2'd0 :
                       (bus.funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
            r_k     <= '0;
            r_err   <= w_illegal;
          end
        end
        S_ISSUE: begin
          r_k <= r_k + 2'd1;
          // ram_q lags the address by one cycle, so it holds byte k-1.
          if (!r_we && (r_k != 2'd0)) begin
            r_bytes[r_k - 2'd1] <= bus.ram_q;
          end
        end
        S_DRAIN: r_rdata <= w_load_result;
        default: ;
      endcase
    end
  end

  // RAM strobes are gated by reset so an aborted store writes nothing more.
  assign w_issue         = (r_state == S_ISSUE) && !reset;
  assign bus.ram_address = w_issue ? (r_base + AWIDTH'(r_k)) : '0;
  assign bus.ram_data    = w_issue ? r_wdata[{r_k, 3'b000} +: 8] : 8'h00;
  assign bus.ram_wren    = w_issue && r_we;

  assign bus.busy  = (r_state != S_IDLE);
  assign bus.done  = (r_state == S_DONE);
  assign bus.err   = (r_state == S_DONE) && r_err;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// Bench for rv32i_dmem_ctrl: directed scenarios plus random accesses, with a
// byte-array memory model and arithmetic load/extension reference.
module tb_rv32i_dmem_ctrl;
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rv32i_dmem_ctrl_if #(.AWIDTH(AW)) bus ();
  rv32i_dmem_ctrl #(.AWIDTH(AW)) dut (.clock(clock), .reset(reset), .bus(bus));

  // Byte RAM with registered read.
  logic [7:0] ram [0:DEPTH-1];
  always @(posedge clock) begin
    if (bus.ram_wren) ram[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= ram[bus.ram_address];
  end

  int wren_cnt = 0;
  int done_cnt = 0;
  always @(posedge clock) begin
    if (bus.ram_wren === 1'b1) wren_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  end

  // Reference state
  logic [7:0]  model_mem [0:DEPTH-1];
  logic [31:0] model_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a, input int k);
    return (int'(a[AW-1:0]) + k) % DEPTH;
  endfunction

  // Runs one access starting at a negedge (cycle T); returns at the negedge
  // of the done cycle. noise: random req traffic while busy. hold: keep the
  // request asserted through done.
  task automatic do_access(input bit w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input bit noise, input bit hold);
    int     n, exp_lat, lat;
    bit     illegal;
    longint val;
    illegal = (f3[1:0] == 2'b11) || (f3[2:1] == 2'b11) || (w && f3[2]);
    n       = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    exp_lat = illegal ? 1 : (w ? n + 1 : n + 2);

    check_val("idle_busy", {31'd0, bus.busy}, 32'd0);
    bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    wren_cnt = 0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); @(negedge clock);
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
      check_val("busy", {31'd0, bus.busy}, 32'd1);
      if (!hold) begin
        if (noise) begin
          bus.req    = 1'($urandom_range(0, 1));
          bus.we     = 1'($urandom_range(0, 1));
          bus.funct3 = 3'($urandom_range(0, 7));
          bus.addr   = $urandom;
          bus.wdata  = $urandom;
        end else begin
          bus.req = 1'b0;
        end
      end
    end
    if (!hold) bus.req = 1'b0;

    check_val("latency", lat, exp_lat);
    check_val("err", {31'd0, bus.err}, {31'd0, illegal});
    check_val("done_wren", {31'd0, bus.ram_wren}, 32'd0);
    check_val("done_addr", {20'd0, bus.ram_address}, 32'd0);
    check_val("wren_cycles", wren_cnt, (w && !illegal) ? n : 0);

    if (!illegal) begin
      if (w) begin
        for (int k = 0; k < n; k++) model_mem[idx_of(a, k)] = 8'((wd >> (8 * k)) & 32'hFF);
        for (int k = 0; k < n; k++) check_val("ram_byte", ram[idx_of(a, k)], model_mem[idx_of(a, k)]);
      end else begin
        val = 0;
        for (int k = 0; k < n; k++) val += longint'(model_mem[idx_of(a, k)]) * (longint'(1) << (8 * k));
        if (!f3[2] && val >= (longint'(1) << (8 * n - 1))) val -= (longint'(1) << (8 * n));
        model_rdata = val[31:0];
      end
    end
    check_val("rdata", bus.rdata, model_rdata);
    $display("access we=%0d f3=%03b addr=0x%03h wdata=0x%08h -> done@T+%0d err=%0d rdata=0x%08h",
             w, f3, a[AW-1:0], wd, lat, bus.err, bus.rdata);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          snap, mism;

    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      ram[i] = d[7:0];
      model_mem[i] = d[7:0];
    end
    model_rdata = 32'd0;
    reset = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    check_val("rst_err", {31'd0, bus.err}, 32'd0);
    check_val("rst_rdata", bus.rdata, 32'd0);
    check_val("rst_wren", {31'd0, bus.ram_wren}, 32'd0);
    check_val("rst_addr", {20'd0, bus.ram_address}, 32'd0);
    check_val("rst_data", {24'd0, bus.ram_data}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // SW then LW
    do_access(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 1'b0, 1'b0);
    check_val("sw_bytes", {ram[16'h13], ram[16'h12], ram[16'h11], ram[16'h10]}, 32'hDEADBEEF);
    @(negedge clock);
    do_access(1'b0, 3'b010, 32'h010, 32'h0, 1'b0, 1'b0);
    check_val("lw_value", bus.rdata, 32'hDEADBEEF);
    @(negedge clock);

    // Byte extension
    do_access(1'b1, 3'b000, 32'h020, 32'h00000080, 1'b0, 1'b0);
    @(negedge clock);
    do_access(1'b0, 3'b000, 32'h020, 32'h0, 1'b0, 1'b0);
    check_val("lb_value", bus.rdata, 32'hFFFFFF80);
    @(negedge clock);
    do_access(1'b0, 3'b100, 32'h020, 32'h0, 1'b0, 1'b0);
    check_val("lbu_value", bus.rdata, 32'h00000080);
    @(negedge clock);

    // Halfword wrap-around (upper address bits ignored)
    do_access(1'b1, 3'b001, 32'hABCD0FFF, 32'h00001234, 1'b0, 1'b0);
    check_val("sh_wrap", {ram[12'h000], ram[12'hFFF]}, 32'h00001234);
    @(negedge clock);
    do_access(1'b0, 3'b001, 32'h00000FFF, 32'h0, 1'b0, 1'b0);
    check_val("lh_wrap", bus.rdata, 32'h00001234);
    @(negedge clock);
    do_access(1'b1, 3'b001, 32'h00000FFF, 32'h00008001, 1'b0, 1'b0);
    @(negedge clock);
    do_access(1'b0, 3'b101, 32'h00000FFF, 32'h0, 1'b0, 1'b0);
    check_val("lhu_value", bus.rdata, 32'h00008001);
    @(negedge clock);
    do_access(1'b0, 3'b001, 32'h00000FFF, 32'h0, 1'b0, 1'b0);
    check_val("lh_neg", bus.rdata, 32'hFFFF8001);
    @(negedge clock);

    // Illegal requests
    do_access(1'b0, 3'b011, 32'h040, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    do_access(1'b1, 3'b100, 32'h040, 32'h11223344, 1'b0, 1'b0);
    @(negedge clock);
    do_access(1'b0, 3'b110, 32'h040, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    do_access(1'b1, 3'b101, 32'h040, 32'h55667788, 1'b0, 1'b0);
    @(negedge clock);

    // Requests while busy are ignored
    do_access(1'b1, 3'b010, 32'h080, 32'hCAFEF00D, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check_val("no_queue", {31'd0, bus.busy}, 32'd0);
    end

    // Request held through done: accepted in the following idle cycle
    do_access(1'b1, 3'b010, 32'h100, 32'h0BADCAFE, 1'b0, 1'b1);
    @(negedge clock);
    check_val("hold_idle", {31'd0, bus.busy}, 32'd0);
    check_val("hold_nodone", {31'd0, bus.done}, 32'd0);
    do_access(1'b1, 3'b010, 32'h100, 32'h0BADCAFE, 1'b0, 1'b0);
    @(negedge clock);

    // Reset in the middle of a SW
    snap = done_cnt;
    wren_cnt = 0;
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h200; bus.wdata = 32'hA1B2C3D4;
    @(posedge clock); @(negedge clock);            // T+1
    bus.req = 1'b0;
    @(posedge clock); @(negedge clock);            // T+2
    reset = 1'b1;
    @(posedge clock); @(negedge clock);            // T+3
    check_val("mid_busy", {31'd0, bus.busy}, 32'd0);
    check_val("mid_done", {31'd0, bus.done}, 32'd0);
    check_val("mid_err", {31'd0, bus.err}, 32'd0);
    check_val("mid_wren", {31'd0, bus.ram_wren}, 32'd0);
    check_val("mid_addr", {20'd0, bus.ram_address}, 32'd0);
    check_val("mid_data", {24'd0, bus.ram_data}, 32'd0);
    check_val("mid_rdata", bus.rdata, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    model_mem[12'h200] = 8'hD4;
    model_rdata = 32'd0;
    check_val("mid_nopulse", done_cnt, snap);
    check_val("mid_wrcnt", wren_cnt, 1);
    for (int k = 0; k < 4; k++) check_val("mid_ram", ram[12'h200 + k], model_mem[12'h200 + k]);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[AW-1:0] = 12'(12'hFFC + $urandom_range(0, 3));
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                ($urandom_range(0, 4) == 0), 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clock);
      @(negedge clock);
    end

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== model_mem[i]) mism++;
    check_val("mem_total", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
